// File: rtl/disp_scan.sv
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  in_ready,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     an
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [DW-1:0] disp_reg, disp_next;
    logic [DW-1:0] pend_reg, pend_next;
    logic          pend_v_reg, pend_v_next;

    logic slot_end;
    logic frame_end;
    logic accept;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);
    assign accept    = in_valid && !pend_v_reg;
    assign in_ready  = !pend_v_reg;

    always_comb begin
        cnt_next    = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next    = idx_reg;
        disp_next   = disp_reg;
        pend_next   = pend_reg;
        pend_v_next = pend_v_reg;
        if (slot_end) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        // Commit only on frame boundaries so one frame never mixes two values.
        if (frame_end && pend_v_reg) begin
            disp_next   = pend_reg;
            pend_v_next = 1'b0;
        end else if (accept) begin
            pend_next   = in_data;
            pend_v_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_v_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            disp_reg   <= disp_next;
            pend_reg   <= pend_next;
            pend_v_reg <= pend_v_next;
        end
    end

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] lit;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = disp_reg[4*gi +: 4];
    end

    always_comb begin
        digit = nib[idx_reg];
    end

`ifdef DISP_SCAN_LZB_EN
    logic [DIGITS-1:0] nz;
    // A digit stays lit if it or any more-significant digit is non-zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
        assign nz[gi]  = |nib[gi];
        assign lit[gi] = (gi == 0) || (|nz[DIGITS-1:gi]);
    end
`else
    assign lit = '1;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
        assign an[gi] = ~((idx_reg == IW'(gi)) && lit[gi]);
    end
endmodule

// File: tb/tb_disp_scan.sv
// Randomized self-checking bench for disp_scan (DIGITS=4, DIV=4) against a
// cycle-count based reference model; honours DISP_SCAN_LZB_EN like the design.
module tb_disp_scan;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [3:0]  digit;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: cycle number since reset release plus the value registers
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pv;

    logic        hold_v;
    logic [15:0] hold_d;

    disp_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .digit    (digit),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic int cur_idx();
        return (t / DIV) % DIGITS;
    endfunction

    function automatic logic [3:0] exp_digit();
        return 4'((m_disp >> (4 * cur_idx())) & 16'hF);
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        int         top;
        a = 4'hF;
        a[cur_idx()] = 1'b0;
`ifdef DISP_SCAN_LZB_EN
        top = 0;
        for (int k = 0; k < DIGITS; k++)
            if (((m_disp >> (4 * k)) & 16'hF) != 0) top = k;
        if (cur_idx() > top) a = 4'hF;
`else
        top = 0;
`endif
        return a;
    endfunction

    // Called at a falling edge; checks outputs, drives inputs, advances one cycle.
    task automatic cycle(input logic v, input logic [15:0] d, output logic acc);
        logic boundary;
        check("an", an, exp_an());
        check("digit", digit, exp_digit());
        check("in_ready", in_ready, !m_pv);
        in_valid = v;
        in_data  = d;
        acc      = v && !m_pv;
        boundary = (t % FRAME) == FRAME - 1;
        @(posedge clk);
        if (boundary && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
            $display("commit t=%0d value=%h", t, m_disp);
        end else if (acc) begin
            m_pend = d;
            m_pv   = 1'b1;
            $display("accept t=%0d value=%h", t, d);
        end
        t++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        hold_v = 1'b0;
        m_disp = '0;
        m_pend = '0;
        m_pv = 1'b0;
        t = 0;
        #1;
        check("rst_an", an, 4'b1110);
        check("rst_digit", digit, 4'h0);
        check("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, acc);
    endtask

    task automatic send_at(input logic [15:0] d, input int max_cycles);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < max_cycles && !acc; i++) cycle(1'b1, d, acc);
        in_valid = 1'b0;
        check("send_timeout", acc, 1'b1);
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0: v = v & 16'h00FF;
            1: v = v & 16'h000F;
            2: v = '0;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic acc;
        hold_v = 1'b0;
        hold_d = '0;
        t = 0;
        @(negedge clk);
        do_reset();

        // scan order and first value committed at cycle 16
        idle(2);
        send_at(16'h12AB, 4);
        send_at(16'h3456, 40);
        check("tp_accept_t", t, 17);
        idle(31);

        // value accepted in a boundary cycle waits a whole frame
        do_reset();
        idle(15);
        send_at(16'hBEEF, 2);
        idle(12);
        check("tp_bnd_digit", digit, 4'h0);
        idle(20);

        // reset mid-frame discards the pending value
        do_reset();
        idle(3);
        send_at(16'h9876, 2);
        idle(5);
        do_reset();
        idle(40);

        // leading-zero patterns
        do_reset();
        send_at(16'h0050, 2);
        idle(40);
        send_at(16'h0000, 2);
        idle(40);

        // randomized producer that holds valid/data until accepted
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (!hold_v && $urandom_range(0, 3) == 0) begin
                hold_v = 1'b1;
                hold_d = rand_value();
            end
            cycle(hold_v, hold_v ? hold_d : 16'($urandom), acc);
            if (acc) hold_v = 1'b0;
            if (i == 1000) begin
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
